// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths, reset/NOP constants, base opcodes
// and the fetch buffer entry layout.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP              = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with modulo-DEPTH pointers and a synchronous flush that
// overrides push/pop; the head output holds its last value while empty.
module fetch_fifo #(
  parameter int unsigned       DEPTH      = 3,
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0,
  localparam int unsigned      CNT_W      = $clog2(DEPTH + 1),
  localparam int unsigned      PTR_W      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_push  = push_i & ~flush_i;
    do_pop   = pop_i & ~flush_i & (count_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= RESET_DATA;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      hold_q   <= head_o;
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: credit-limited word fetches into a small buffer, delivered
// to decode over valid/ready; redirects flush the buffer and drop in-flight data.
module instruction_fetch
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] instruction,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] fifo_count;
  logic [XLEN-1:0]  redirect_tgt;
  logic             credit_ok, grant, push, pop;
  fetch_entry_t     head, push_entry;

  // Buffered plus in-flight words never exceed DEPTH, so a push always has room.
  assign credit_ok   = (SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
  assign imem_req    = rst_n & ~redirect_valid & credit_ok;
  assign imem_addr   = fetch_pc_q;
  assign inst_valid  = (fifo_count != '0) & ~redirect_valid;
  assign instruction = head.word;
  assign inst_pc     = head.pc;

  always_comb begin
    grant         = imem_req & imem_gnt;
    pop           = inst_valid & inst_ready;
    push          = imem_rvalid & (drop_cnt_q == '0) & ~redirect_valid;
    redirect_tgt  = word_align(redirect_pc);
    push_entry    = '{pc: resp_pc_q, word: imem_rdata};
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(imem_rvalid);
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)  resp_pc_d  = resp_pc_q + XLEN'(4);
      if (imem_rvalid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (DEPTH),
    .WIDTH      (XLEN + ILEN),
    .RESET_DATA ({RESET_PC, {ILEN{1'b0}}})
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) !(imem_rvalid && (outstanding_q == '0)));

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RV32I core, directly upstream of the instruction decoder. Issues word-aligned fetch requests to instruction memory over a request/grant, in-order response interface. Buffers returned words with their PCs in a small FIFO and presents them to decode through a valid/ready handshake. Handles PC redirects from branch/jump resolution by flushing buffered words and discarding in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset (bits [1:0] must be 0).
- DEPTH, 3: FIFO entries and maximum outstanding-plus-buffered words; legal range 2..8.

- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, always word aligned.
- imem_gnt  in  1  request accepted this cycle when high together with imem_req.
- imem_rvalid  in  1  response data valid; responses in grant order, at least 1 cycle after grant.
- imem_rdata  in  32  response instruction word.
- redirect_valid  in  1  load new PC this cycle.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.
- inst_valid  out  1  instruction/inst_pc valid to decode.
- inst_ready  in  1  decode accepts the head entry.
- instruction  out  32  head instruction word, to decoder `instruction` input.
- inst_pc  out  32  PC of head instruction.

## Operation
- Registers: fetch_pc, resp_pc, outstanding (0..DEPTH), drop_cnt (0..DEPTH), FIFO of {pc, word} with count.
- imem_addr = fetch_pc. imem_req = rst_n & !redirect_valid & (count + outstanding < DEPTH), using registered values only (no combinational path from inst_ready).
- Grant (imem_req & imem_gnt): fetch_pc += 4 (mod 2^32), outstanding += 1.
- Response (imem_rvalid): outstanding -= 1. If drop_cnt > 0: drop_cnt -= 1, word discarded. Else push {resp_pc, imem_rdata}, resp_pc += 4.
- Pop: inst_valid & inst_ready. Push and pop in the same cycle are both performed; credit rule guarantees a push never meets a full FIFO.
- inst_valid = (count != 0) & !redirect_valid. instruction/inst_pc = head entry; when empty, they hold the last head value (reset value 0 / RESET_PC).
- Redirect cycle: FIFO flushed (count = 0, pointers reset), pop ignored, no request issued. fetch_pc and resp_pc <= {redirect_pc[31:2], 2'b00}. Any rvalid in that cycle is discarded. drop_cnt <= outstanding - imem_rvalid, which equals every response still in flight. outstanding keeps its normal update.
- Back-to-back redirects: each one recomputes drop_cnt from the current outstanding; the last one wins for PC.
- imem_rvalid with outstanding == 0 is a protocol violation. Behaviour is unspecified; simulation asserts.

## Timing
- Reset (async assert): imem_req 0, inst_valid 0, instruction 0, inst_pc RESET_PC, fetch_pc = resp_pc = RESET_PC, counters 0, FIFO empty.
- First clock edge after deassertion: imem_req 1, imem_addr RESET_PC.
- Latency: grant at cycle N, rvalid at N+1 earliest, inst_valid at N+2 (FIFO output is registered state).
- Throughput: with DEPTH=3, 1-cycle memory latency and inst_ready held high, one instruction per cycle steady state.
- Redirect at cycle R: imem_req high at R+1 with imem_addr = redirect target. The earliest valid redirected instruction appears at R+3.
- Reset asserted mid-operation: all state cleared immediately. In-flight memory responses after reset are the memory's responsibility to squash.

## Structure
- Shared package rv32i_pkg: XLEN = 32, ILEN = 32, RESET_PC default, NOP = 32'h0000_0013, and the opcode constants the decoder already uses.
- Sub-module fetch_fifo: synchronous FIFO, parameter DEPTH, width 64 ({pc, word}), with push, pop and a synchronous flush. Flush has priority over push and pop. It exposes count. Pointers wrap modulo DEPTH, not power of two.
- instruction_fetch holds the PC, credit and drop counters and instantiates one fetch_fifo.

## Test plan
- Reset release, memory grants every cycle with 1-cycle latency, inst_ready=1 -> addresses 0x0,0x4,0x8… on consecutive cycles, inst_valid continuous from cycle 2, inst_pc matching each word.
- inst_ready=0 for 10 cycles -> exactly DEPTH requests issued, imem_req low afterwards, no words lost. The FIFO drains in order once ready returns.
- Redirect to 0x100 with 2 requests outstanding -> both responses dropped, FIFO empty, next imem_addr 0x100, first delivered inst_pc 0x100.
- redirect_pc = 0x203 -> fetch address 0x200. Redirect coincident with rvalid and pop -> that response discarded, no pop credited.
- imem_gnt randomly low 50%, variable response latency 1–4 cycles -> instruction stream in order, PCs consecutive, count + outstanding never exceeds DEPTH.
- fetch_pc at 0xFFFF_FFFC -> next address 0x0000_0000. rst_n asserted mid-stream -> outputs return to reset values asynchronously.
